// File: rtl/rand_pkg.sv
// Shared types and helpers for the random range generator and its LFSR core.
package rand_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    DRAW = 1'b1
  } state_t;

  // Default Fibonacci feedback masks per LFSR width
  localparam logic [2:0]  TAPS_W3  = 3'b110;
  localparam logic [15:0] TAPS_W16 = 16'hB400;

  function automatic int unsigned mod_inc(input int unsigned x, input int unsigned range);
    return (x + 32'd1 >= range) ? 32'd0 : x + 32'd1;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Free-running Fibonacci LFSR with seed load; a zero seed maps to all ones so
// the lock-up state can never be entered.
module lfsr_core #(
  parameter int unsigned       W    = 16,
  parameter logic [W-1:0]      TAPS = W'(16'hB400)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] seed,
  output logic [W-1:0] state
);

  logic fb;

  assign fb = ^(state & TAPS);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= '1;
    end else if (load) begin
      state <= (seed == '0) ? '1 : seed;
    end else begin
      state <= {state[W-2:0], fb};
    end
  end

endmodule

// File: rtl/rand_range_gen.sv
// Request-driven uniform symbol generator: rejection sampling on an LFSR with a
// bounded-retry fallback and a consecutive-repeat limiter.
module rand_range_gen
  import rand_pkg::*;
#(
  parameter int unsigned            LFSR_W     = 16,
  parameter logic [LFSR_W-1:0]      TAPS       = LFSR_W'(TAPS_W16),
  parameter int unsigned            OUT_W      = 2,
  parameter int unsigned            RANGE      = 3,
  parameter int unsigned            MAX_REPEAT = 3,
  parameter int unsigned            RETRY_MAX  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              req,
  output logic              busy,
  output logic              valid,
  output logic [OUT_W-1:0]  value
);

  localparam int unsigned RETRY_W  = (RETRY_MAX > 1) ? $clog2(RETRY_MAX) : 1;
  localparam int unsigned REP_W    = (MAX_REPEAT > 0) ? $clog2(MAX_REPEAT + 1) : 1;
  localparam bit          LIMIT_ON = (MAX_REPEAT > 0) && (RANGE > 1);

  if (LFSR_W < 2) begin : g_bad_lfsr_w
    $error("rand_range_gen: LFSR_W must be >= 2");
  end
  if (OUT_W < 1 || OUT_W > LFSR_W) begin : g_bad_out_w
    $error("rand_range_gen: OUT_W must be in 1..LFSR_W");
  end
  if (RANGE < 1 || RANGE > (32'd1 << OUT_W)) begin : g_bad_range
    $error("rand_range_gen: RANGE must be in 1..2**OUT_W");
  end
  if (RETRY_MAX < 1) begin : g_bad_retry
    $error("rand_range_gen: RETRY_MAX must be >= 1");
  end

  state_t               state_q, state_d;
  logic [LFSR_W-1:0]    lfsr;
  logic [OUT_W-1:0]     cand;
  logic                 cand_ok_c;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic [OUT_W-1:0]     wrap_q, wrap_d;
  logic [OUT_W-1:0]     last_q;
  logic [REP_W-1:0]     rep_q, rep_d;
  logic                 accept_c;
  logic [OUT_W-1:0]     pick_c, final_c;
  logic                 busy_d;
  logic                 unused_lfsr_c;

  lfsr_core #(
    .W    (LFSR_W),
    .TAPS (TAPS)
  ) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (seed_load),
    .seed    (seed),
    .state   (lfsr)
  );

  assign cand          = lfsr[OUT_W-1:0];
  assign cand_ok_c     = ({1'b0, cand} < (OUT_W + 1)'(RANGE));
  assign unused_lfsr_c = ^lfsr;
  assign wrap_d        = (wrap_q == OUT_W'(RANGE - 1)) ? '0 : wrap_q + 1'b1;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, retry count and accepted candidate
  always_comb begin
    state_d  = state_q;
    retry_d  = retry_q;
    accept_c = 1'b0;
    pick_c   = cand;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d = DRAW;
          retry_d = '0;
        end
      end
      DRAW: begin
        if (cand_ok_c) begin
          accept_c = 1'b1;
        end else if (retry_q == RETRY_W'(RETRY_MAX - 1)) begin
          accept_c = 1'b1;
          pick_c   = wrap_q;
        end else begin
          retry_d = retry_q + 1'b1;
        end
        if (accept_c) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: busy tracks DRAW; repeat limiter nudges a run that hit the cap
  always_comb begin
    busy_d  = (state_d == DRAW);
    final_c = pick_c;
    rep_d   = rep_q;
    if (LIMIT_ON) begin
      if (pick_c == last_q && rep_q == REP_W'(MAX_REPEAT)) begin
        final_c = OUT_W'(mod_inc(32'(pick_c), RANGE));
        rep_d   = REP_W'(1);
      end else if (pick_c == last_q) begin
        rep_d = rep_q + 1'b1;
      end else begin
        rep_d = REP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      retry_q <= '0;
      wrap_q  <= '0;
      last_q  <= '0;
      rep_q   <= '0;
      busy    <= 1'b0;
      valid   <= 1'b0;
      value   <= '0;
    end else begin
      retry_q <= retry_d;
      wrap_q  <= wrap_d;
      busy    <= busy_d;
      valid   <= accept_c;
      if (accept_c) begin
        value  <= final_c;
        last_q <= final_c;
        rep_q  <= rep_d;
      end
    end
  end

endmodule

// File: tb/tb_rand_range_gen.sv
// Scoreboard bench for rand_range_gen: directed draws on small 3-bit LFSR
// instances plus bulk limiter/histogram runs on a 16-bit instance.
module tb_rand_range_gen;

  typedef struct {
    logic [1:0] v;
    int         cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        seed_load;
  logic [2:0]  seed;
  logic        req_a, req_b, req_c, req_d;
  logic        busy_a, busy_b, busy_c, busy_d;
  logic        valid_a, valid_b, valid_c, valid_d;
  logic [1:0]  value_a, value_b, value_c, value_d;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   wrap_m   = 0;
  exp_t exp_a[$];
  exp_t exp_b[$];

  int         n_c = 0, n_d = 0, run_d = 0;
  bit         have_c = 0, have_d = 0;
  logic [1:0] prev_c, prev_d;
  int         hist[3] = '{0, 0, 0};

  always #5 clk = ~clk;

  rand_range_gen #(.LFSR_W(3), .TAPS(3'b110), .OUT_W(2), .RANGE(3), .MAX_REPEAT(3), .RETRY_MAX(4))
    u_a (.clk(clk), .reset_n(reset_n), .seed_load(seed_load), .seed(seed), .req(req_a),
         .busy(busy_a), .valid(valid_a), .value(value_a));

  rand_range_gen #(.LFSR_W(3), .TAPS(3'b110), .OUT_W(2), .RANGE(3), .MAX_REPEAT(3), .RETRY_MAX(1))
    u_b (.clk(clk), .reset_n(reset_n), .seed_load(seed_load), .seed(seed), .req(req_b),
         .busy(busy_b), .valid(valid_b), .value(value_b));

  rand_range_gen #(.LFSR_W(3), .TAPS(3'b110), .OUT_W(2), .RANGE(3), .MAX_REPEAT(1), .RETRY_MAX(4))
    u_c (.clk(clk), .reset_n(reset_n), .seed_load(seed_load), .seed(seed), .req(req_c),
         .busy(busy_c), .valid(valid_c), .value(value_c));

  rand_range_gen #(.LFSR_W(16), .TAPS(16'hB400), .OUT_W(2), .RANGE(3), .MAX_REPEAT(3), .RETRY_MAX(4))
    u_d (.clk(clk), .reset_n(reset_n), .seed_load(1'b0), .seed(16'h0000), .req(req_d),
         .busy(busy_d), .valid(valid_d), .value(value_d));

  // Cycle index and reference wrap counter (0..RANGE-1, cleared by reset)
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset_n) wrap_m <= 0;
    else          wrap_m <= (wrap_m == 2) ? 0 : wrap_m + 1;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic chk_cond(input string name, input bit ok, input int got);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s got=%0d (cycle %0d)", name, got, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input int v, input int c);
    exp_t e;
    e.v = 2'(v);
    e.cyc = c;
    exp_a.push_back(e);
  endtask

  task automatic push_b(input int v, input int c);
    exp_t e;
    e.v = 2'(v);
    e.cyc = c;
    exp_b.push_back(e);
  endtask

  // Scoreboard monitors for the directed instances
  always @(negedge clk) begin
    exp_t e;
    if (valid_a === 1'b1) begin
      checks++;
      if (exp_a.size() == 0) begin
        failures++;
        $display("FAIL a_unexpected_valid got value=%0d want no valid (cycle %0d)", value_a, cyc);
      end else begin
        e = exp_a.pop_front();
        chk("a_value", 32'(value_a), 32'(e.v));
        chk("a_valid_cycle", cyc, e.cyc);
      end
    end
    if (valid_b === 1'b1) begin
      checks++;
      if (exp_b.size() == 0) begin
        failures++;
        $display("FAIL b_unexpected_valid got value=%0d want no valid (cycle %0d)", value_b, cyc);
      end else begin
        e = exp_b.pop_front();
        chk("b_value", 32'(value_b), 32'(e.v));
        chk("b_valid_cycle", cyc, e.cyc);
      end
    end
  end

  // Property monitors for the bulk limiter runs
  always @(negedge clk) begin
    if (valid_c === 1'b1) begin
      chk_cond("c_range", value_c < 2'd3, int'(value_c));
      if (have_c) chk_cond("c_no_repeat", value_c != prev_c, int'(value_c));
      prev_c = value_c;
      have_c = 1'b1;
      n_c++;
    end
    if (valid_d === 1'b1) begin
      run_d = (have_d && value_d == prev_d) ? run_d + 1 : 1;
      chk_cond("d_run_le3", run_d <= 3, run_d);
      chk_cond("d_range", value_d < 2'd3, int'(value_d));
      if (value_d < 2'd3) hist[value_d]++;
      prev_d = value_d;
      have_d = 1'b1;
      n_d++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout got=%0d want=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int lim_vals[4] = '{1, 1, 1, 2};
    reset_n = 1'b0; seed_load = 1'b0; seed = 3'd0;
    req_a = 1'b0; req_b = 1'b0; req_c = 1'b0; req_d = 1'b0;

    // Reset values
    tick(); tick();
    @(negedge clk);
    chk("rst_value", 32'(value_a), 0);
    chk("rst_valid", 32'(valid_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_lfsr", 32'(u_a.u_lfsr.state), 7);
    tick(); reset_n = 1'b1;
    tick();

    // Direct accept: seed 001 with req in the same cycle
    tick(); c = cyc; seed_load = 1'b1; seed = 3'b001; req_a = 1'b1; push_a(1, c + 2);
    tick(); seed_load = 1'b0; req_a = 1'b0;
    @(negedge clk); chk("acc_busy", 32'(busy_a), 1);
    tick();

    // Rejection: 11, 11, 10 -> 2; req held through DRAW must not queue
    tick(); c = cyc; seed_load = 1'b1; seed = 3'b011; req_a = 1'b1; push_a(2, c + 4);
    tick(); seed_load = 1'b0;
    @(negedge clk); chk("rej_busy", 32'(busy_a), 1);
    tick(); tick();
    tick(); req_a = 1'b0;
    @(negedge clk); chk("rej_idle_busy", 32'(busy_a), 0);

    // Limiter at MAX_REPEAT=3: fourth identical candidate is bumped to 2
    for (int i = 0; i < 4; i++) begin
      tick(); c = cyc; seed_load = 1'b1; seed = 3'b001; req_a = 1'b1; push_a(lim_vals[i], c + 2);
      tick(); seed_load = 1'b0; req_a = 1'b0;
    end

    // Zero seed maps to all ones
    tick(); seed_load = 1'b1; seed = 3'b000;
    tick(); seed_load = 1'b0;
    @(negedge clk); chk("zero_seed_lfsr", 32'(u_a.u_lfsr.state), 7);

    // Seed reload mid-DRAW: draw continues on the new stream
    tick(); c = cyc; seed_load = 1'b1; seed = 3'b011; req_a = 1'b1; push_a(1, c + 3);
    tick(); seed = 3'b001; req_a = 1'b0;
    tick(); seed_load = 1'b0;
    tick();

    // Handshake: req held high gives one valid per draw
    tick(); c = cyc; seed_load = 1'b1; seed = 3'b001; req_a = 1'b1;
    push_a(1, c + 2); push_a(1, c + 4); push_a(2, c + 7); push_a(1, c + 9); push_a(1, c + 11);
    tick(); seed_load = 1'b0;
    repeat (9) tick();
    req_a = 1'b0;
    repeat (2) tick();

    // Reset mid-DRAW aborts the draw
    tick(); seed_load = 1'b1; seed = 3'b011; req_a = 1'b1;
    tick(); seed_load = 1'b0; req_a = 1'b0; reset_n = 1'b0;
    tick(); reset_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy_a), 0);
    chk("mid_rst_valid", 32'(valid_a), 0);
    chk("mid_rst_value", 32'(value_a), 0);
    chk("mid_rst_lfsr", 32'(u_a.u_lfsr.state), 7);
    repeat (4) tick();
    @(negedge clk); chk("mid_rst_idle", 32'(busy_a), 0);

    // Fallback with RETRY_MAX=1: value is wrap in the DRAW cycle
    for (int i = 0; i < 2; i++) begin
      tick(); c = cyc; seed_load = 1'b1; seed = 3'b011; req_b = 1'b1;
      tick(); seed_load = 1'b0; req_b = 1'b0; push_b(wrap_m, c + 2);
    end
    repeat (3) tick();

    // MAX_REPEAT=1 bulk run
    req_c = 1'b1;
    for (int i = 0; i < 2000 && n_c < 200; i++) tick();
    req_c = 1'b0;
    chk_cond("c_done", n_c >= 200, n_c);
    repeat (6) tick();

    // 16-bit bulk run: run-length cap and loose per-symbol share; a reject
    // biases the next candidate toward 2, so bounds are 1/6..2/3
    req_d = 1'b1;
    for (int i = 0; i < 5000 && n_d < 600; i++) tick();
    req_d = 1'b0;
    chk_cond("d_done", n_d >= 600, n_d);
    repeat (6) tick();
    for (int s = 0; s < 3; s++) begin
      chk_cond($sformatf("d_hist_%0d", s), (hist[s] * 6 >= n_d) && (hist[s] * 3 <= n_d * 2), hist[s]);
    end

    chk("a_queue_drained", exp_a.size(), 0);
    chk("b_queue_drained", exp_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
